// File: rtl/neuron_act_seq.sv
// Single neuron: bias + sum of N_IN signed x*w products, then ReLU with positive saturation.
// Latency: start in cycle 0, pairs in cycles 1..N_IN, ACT in N_IN+1, out_valid from N_IN+2 (+1 per idle ACCUM cycle).
// Backpressure: in_ready only while accumulating; result held in HOLD until out_ready, start ignored while busy.
module neuron_act_seq #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     act_sel,
    output logic                     busy
);

    localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
    localparam int CNT_W = $clog2(N_IN) + 1;
    localparam int PRD_W = 2*DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
    // Largest positive value representable in the output width, widened to the accumulator.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic                     xfer;
    logic                     load;
    logic                     do_act;
    logic signed [PRD_W-1:0]  x_ext, w_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext;
    logic signed [DATA_W-1:0] act_val;

    // Full-precision product, operands widened first so the multiply is done at 2*DATA_W.
    assign x_ext    = {{DATA_W{in_x[DATA_W-1]}}, in_x};
    assign w_ext    = {{DATA_W{in_w[DATA_W-1]}}, in_w};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign xfer     = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE, so it is never queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && (cnt == CNT_LAST)) state_nxt = ACT;
            ACT:     state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs and datapath strobes decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        do_act    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                load = start;
            end
            ACCUM:   in_ready  = 1'b1;
            ACT:     do_act    = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // ReLU with clamp: negative -> 0, above the output range -> SAT_MAX.
    always_comb begin
        act_val = acc[DATA_W-1:0];
        if (acc[ACC_W-1]) begin
            act_val = '0;
        end else if (acc > SAT_MAX) begin
            act_val = SAT_MAX[DATA_W-1:0];
        end
    end

    // Accumulator, pair counter and result registers; results persist until the next ACT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            act_sel  <= 1'b0;
        end else begin
            if (load) begin
                acc <= bias_ext;
                cnt <= '0;
            end else if (xfer) begin
                acc <= acc + prod_ext;
                cnt <= cnt + CNT_W'(1);
            end
            if (do_act) begin
                act_sel  <= acc[ACC_W-1];
                out_data <= act_val;
            end
        end
    end

endmodule

// File: tb/tb_neuron_act_seq.sv
// Directed bench for neuron_act_seq at N_IN=4, DATA_W=8.
// Vector table of full evaluations plus hand sequences for HOLD stall and mid-run reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_neuron_act_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic signed [7:0] bias;
    logic              in_valid;
    logic signed [7:0] in_x;
    logic signed [7:0] in_w;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              act_sel;
    logic              busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] prev_out;

    typedef struct packed {
        logic [7:0]       bias;
        logic [3:0][7:0]  xs;
        logic [3:0][7:0]  ws;
        logic             gapped;
        logic [7:0]       exp_out;
        logic             exp_act;
        logic [7:0]       exp_lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    neuron_act_seq #(.N_IN(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .act_sel   (act_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int b,
                           input int x0, input int w0, input int x1, input int w1,
                           input int x2, input int w2, input int x3, input int w3,
                           input bit gap, input int eo, input bit ea, input int lat);
        vecs[i].bias    = 8'(b);
        vecs[i].xs[0]   = 8'(x0);
        vecs[i].ws[0]   = 8'(w0);
        vecs[i].xs[1]   = 8'(x1);
        vecs[i].ws[1]   = 8'(w1);
        vecs[i].xs[2]   = 8'(x2);
        vecs[i].ws[2]   = 8'(w2);
        vecs[i].xs[3]   = 8'(x3);
        vecs[i].ws[3]   = 8'(w3);
        vecs[i].gapped  = gap;
        vecs[i].exp_out = 8'(eo);
        vecs[i].exp_act = ea;
        vecs[i].exp_lat = 8'(lat);
    endtask

    // One evaluation; hold = cycles out_ready stays low in HOLD, pulse = start asserted meanwhile.
    task automatic run(input vec_t v, input int hold, input bit pulse);
        int   idx  = 0;
        int   cyc  = 0;
        int   seen = -1;
        logic rdy_s;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_in_ready", int'(in_ready), 0);
        start = 1'b1;
        bias  = v.bias;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("out_data_kept", int'(out_data), int'(prev_out));
        chk("accum_busy", int'(busy), 1);
        while (seen < 0 && cyc < 40) begin
            if (out_valid) begin
                seen = cyc;
            end else begin
                rdy_s    = in_ready;
                in_valid = (idx < 4) && (!v.gapped || (cyc % 2 == 1));
                if (idx < 4) begin
                    in_x = v.xs[idx];
                    in_w = v.ws[idx];
                end
                @(posedge clk);
                if (rdy_s && in_valid) idx++;
                @(negedge clk);
                in_valid = 1'b0;
                cyc++;
            end
        end
        chk("latency", seen, int'(v.exp_lat));
        chk("hold_in_ready", int'(in_ready), 0);
        chk("out_data", int'(out_data), int'(v.exp_out));
        chk("act_sel", int'(act_sel), int'(v.exp_act));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = pulse;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), int'(v.exp_out));
            chk("stall_act", int'(act_sel), int'(v.exp_act));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("drain_valid", int'(out_valid), 0);
        chk("drain_busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("no_restart_busy", int'(busy), 0);
        prev_out = v.exp_out;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        prev_out  = 8'd0;

        //       i  bias   x0   w0  x1   w1  x2  w2  x3  w3  gap out act lat
        set_vec(0,    0,   3,   2, -1,   4,  5,  1,  2,  2,  0, 11, 0, 6);
        set_vec(1,    0,   3,   2, -1,   4,  5,  1,  2,  2,  1, 11, 0, 9);
        set_vec(2,  -10,   1,   1,  1,   1,  1,  1,  1,  1,  0,  0, 1, 6);
        set_vec(3,    0,   0,   5,  7,   0,  0,  0,  0, -3,  0,  0, 0, 6);
        set_vec(4,  127,   0,   0,  0,   0,  0,  0,  0,  0,  0, 127, 0, 6);
        set_vec(5,  127,   1,   1,  0,   0,  0,  0,  0,  0,  0, 127, 0, 6);
        set_vec(6,    0,  -1,   1,  0,   0,  0,  0,  0,  0,  0,  0, 1, 6);
        set_vec(7, -128,-128,-128,-128,-128,-128,-128,-128,-128, 0, 127, 0, 6);
        set_vec(8,    0,-128, 127,-128, 127,-128, 127,-128, 127, 0,  0, 1, 6);
        set_vec(9,   20,  -3,   4,  2,  -2,  1,  1,  0,  0,  0,  5, 0, 6);
        set_vec(10, 100, 127, 127, 127, 127, 127, 127, 127, 127, 0, 127, 0, 6);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_act_sel", int'(act_sel), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run(vecs[i], 0, 1'b0);
        end

        // Long stall in HOLD with start pulsed throughout.
        run(vecs[0], 5, 1'b1);

        // Abort after two pairs, then a clean evaluation.
        @(negedge clk);
        start = 1'b1;
        bias  = 8'sd100;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_x     = 8'sd127;
        in_w     = 8'sd127;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_act_sel", int'(act_sel), 0);
        prev_out = 8'd0;
        run(vecs[2], 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
